// File: rtl/gd_frame_sync.sv
// Frame-synchronous hand-off of the game-data bundle to the draw pipeline.
// A bundle is staged on request and copied to the shadow only at frame start.
module gd_frame_sync #(
  parameter int   DATA_WIDTH   = 512,
  parameter logic VS_POL       = 1'b0,
  parameter int   BLINK_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_vs_i,
  input  logic                  gd_valid_i,
  input  logic [DATA_WIDTH-1:0] gd_data_i,
  output logic                  gd_ready_o,
  output logic [DATA_WIDTH-1:0] gd_shadow_o,
  output logic                  commit_o,
  output logic [15:0]           frame_cnt_o,
  output logic                  blink_o,
  output logic                  pending_o
);

  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  state_t                state;
  state_t                state_next;
  logic                  vs_d;
  logic                  fs;
  logic [DATA_WIDTH-1:0] staging;
  logic [7:0]            blink_cnt;

  // Frame start is the first cycle vsync sits at its active level.
  assign fs = (pix_vs_i == VS_POL) && (vs_d != VS_POL);

  always_comb begin
    state_next = state;
    gd_ready_o = 1'b0;
    pending_o  = 1'b0;
    commit_o   = 1'b0;
    case (state)
      IDLE: begin
        gd_ready_o = !rst;
        if (gd_valid_i) state_next = PENDING;
      end
      PENDING: begin
        pending_o = 1'b1;
        if (fs) state_next = COMMIT;
      end
      COMMIT: begin
        commit_o   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      vs_d        <= VS_POL;
      staging     <= '0;
      gd_shadow_o <= '0;
      frame_cnt_o <= '0;
      blink_cnt   <= '0;
      blink_o     <= 1'b0;
    end else begin
      state <= state_next;
      vs_d  <= pix_vs_i;
      if (state == IDLE && gd_valid_i) staging <= gd_data_i;
      if (state == PENDING && fs) gd_shadow_o <= staging;
      // Both counters advance on every frame start regardless of the hand-off state.
      if (fs) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_o   <= ~blink_o;
        end else begin
          blink_cnt <= blink_cnt + 8'd1;
        end
      end
    end
  end

endmodule
